// File: rtl/traffic_light_counter.sv
// Free-running 6-bit phase timer: counts up to a selectable terminal value,
// flags it, and wraps to zero on the following edge.
module traffic_light_counter #(
  parameter int unsigned LIMIT_LONG  = 29,
  parameter int unsigned LIMIT_SHORT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_compare,
  output logic [5:0] cnt,
  output logic       over_flag
);

  localparam logic [5:0] LIMIT_LONG_C  = LIMIT_LONG[5:0];
  localparam logic [5:0] LIMIT_SHORT_C = LIMIT_SHORT[5:0];

  // Power-up value lets the timer run correctly even if reset is never asserted.
  logic [5:0] cnt_r = 6'd0;
  logic [5:0] limit_s;
  logic       over_s;

  // Active limit and terminal-count detect; >= makes a lowered limit end the phase at once.
  always_comb begin
    limit_s = LIMIT_LONG_C;
    if (sel_compare == 1'b1) begin
      limit_s = LIMIT_SHORT_C;
    end else begin
      limit_s = LIMIT_LONG_C;
    end
    over_s = (cnt_r >= limit_s);
  end

  // Counter update: reset wins over wrap, wrap wins over increment.
  always_ff @(posedge clk) begin
    if (reset == 1'b1) begin
      cnt_r <= 6'd0;
    end else if (over_s == 1'b1) begin
      cnt_r <= 6'd0;
    end else begin
      cnt_r <= cnt_r + 6'd1;
    end
  end

  assign cnt       = cnt_r;
  assign over_flag = over_s;

endmodule

// File: tb/tb_traffic_light_counter.sv
// Self-checking bench for traffic_light_counter: directed test-plan steps
// followed by randomized reset/select traffic, checked against a reference model.
module tb_traffic_light_counter;

  localparam int LONG_L  = 29;
  localparam int SHORT_L = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sel_compare = 1'b0;
  logic [5:0] cnt;
  logic       over_flag;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;   // reference: phase position in ticks
  int seen_flags = 0;

  traffic_light_counter #(.LIMIT_LONG(LONG_L), .LIMIT_SHORT(SHORT_L)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel_compare(sel_compare),
    .cnt        (cnt),
    .over_flag  (over_flag)
  );

  always #5 clk = ~clk;

  function automatic int limit_of(input logic sel);
    return (sel == 1'b1) ? SHORT_L : LONG_L;
  endfunction

  // Apply inputs, check outputs mid-cycle, then advance one clock and update the model.
  task automatic step(input logic r, input logic s);
    logic exp_flag;
    reset = r;
    sel_compare = s;
    #1;
    exp_flag = (model_cnt >= limit_of(s));
    checks++;
    assert (cnt === 6'(model_cnt)) else begin
      errors++;
      $error("FAIL cnt: got %0d expected %0d", cnt, model_cnt);
    end
    checks++;
    assert (over_flag === exp_flag) else begin
      errors++;
      $error("FAIL over_flag: got %0b expected %0b (cnt=%0d sel=%0b)", over_flag, exp_flag, model_cnt, s);
    end
    if (exp_flag) seen_flags++;
    @(posedge clk);
    if (r) model_cnt = 0;
    else if (exp_flag) model_cnt = 0;
    else model_cnt = model_cnt + 1;
    @(negedge clk);
  endtask

  task automatic check_const(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int guard;
    // Power-up, long phase: 30 cycles back to 0, then another full period.
    seen_flags = 0;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    #1 check_const("wrap_after_30", int'(cnt), 0);
    check_const("one_flag_per_long_period", seen_flags, 1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    check_const("second_wrap", int'(cnt), 0);

    // Short phase from cnt = 0: period 5.
    seen_flags = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    check_const("short_flags_two_periods", seen_flags, 2);
    check_const("short_wrap", int'(cnt), 0);

    // Count long to 10, then drop to short limit: flag at once, wrap next edge.
    guard = 0;
    while (model_cnt != 10 && guard < 100) begin step(1'b0, 1'b0); guard++; end
    check_const("reach_10", int'(cnt), 10);
    sel_compare = 1'b1;
    #1 check_const("lowered_flag_now", int'(over_flag), 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);

    // Short count to 3, then raise limit: continues 4..29 with single flag.
    guard = 0;
    while (model_cnt != 3 && guard < 100) begin step(1'b0, 1'b1); guard++; end
    check_const("reach_3", int'(cnt), 3);
    seen_flags = 0;
    for (int i = 0; i < 27; i++) step(1'b0, 1'b0);
    check_const("raised_single_flag", seen_flags, 1);

    // Reset pulse at 17.
    guard = 0;
    while (model_cnt != 17 && guard < 100) begin step(1'b0, 1'b0); guard++; end
    step(1'b1, 1'b0);
    check_const("reset_at_17", int'(cnt), 0);
    step(1'b0, 1'b0);
    check_const("resume_after_reset", int'(cnt), 1);

    // Reset coinciding with terminal count.
    guard = 0;
    while (model_cnt != 29 && guard < 100) begin step(1'b0, 1'b0); guard++; end
    step(1'b1, 1'b0);
    check_const("reset_at_29", int'(cnt), 0);
    check_const("flag_dropped", int'(over_flag), 0);

    // Multi-cycle reset, then resume.
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i % 2));
    step(1'b0, 1'b0);
    check_const("resume_multi_reset", int'(cnt), 1);

    // Randomized reset/select traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? ~sel_compare : sel_compare);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
